// File: rtl/md_unit_ctrl_if.sv
// Handshake and result bundle between the E-stage pipeline/hazard unit and the
// multiply/divide controller.
interface md_unit_ctrl_if;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_uses_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_valid, md_op, rs_val, rt_val, d_uses_md,
    input  start, busy, md_stall, hi, lo
  );

  modport slave (
    input  md_valid, md_op, rs_val, rt_val, d_uses_md,
    output start, busy, md_stall, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide controller: computes the 64-bit result at issue, holds it
// pending for a fixed busy window, then commits it to HI/LO.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_ctrl_if.slave md
);
  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   pend_hi_p1, pend_lo_p1;
  logic                pend_wr_p1;
  logic                is_mul, is_div, is_signed, start, finish;
  logic [2*DATA_W-1:0] res_p0;

  function automatic logic [2*DATA_W-1:0] mul_res(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sa, sb;
    logic        [2*DATA_W-1:0] ua, ub;
    sa = $signed({{DATA_W{a[DATA_W-1]}}, a});
    sb = $signed({{DATA_W{b[DATA_W-1]}}, b});
    ua = {{DATA_W{1'b0}}, a};
    ub = {{DATA_W{1'b0}}, b};
    if (sgn) mul_res = $unsigned(sa * sb);
    else     mul_res = ua * ub;
  endfunction

  // Returns {remainder, quotient}; the most-negative / -1 case is pinned so it never traps.
  function automatic logic [2*DATA_W-1:0] div_res(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb, sq, sr;
    logic        [DATA_W-1:0] uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (b != '0) begin
      if (sgn) begin
        if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == {DATA_W{1'b1}}) begin
          sq = sa;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
        end
      end else begin
        uq = a / b;
        ur = a % b;
      end
    end
    div_res = sgn ? {sr, sq} : {ur, uq};
  endfunction

  assign is_mul    = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
  assign is_div    = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
  assign is_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);
  assign start     = md.md_valid && (is_mul || is_div) && (state_q == IDLE);
  assign finish    = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  assign res_p0    = is_div ? div_res(is_signed, md.rs_val, md.rt_val)
                            : mul_res(is_signed, md.rs_val, md.rt_val);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = BUSY;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (finish) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // p0 -> p1: result captured at issue; committed to HI/LO when the window closes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_p1 <= '0;
      pend_lo_p1 <= '0;
      pend_wr_p1 <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (start) begin
        pend_hi_p1 <= res_p0[2*DATA_W-1:DATA_W];
        pend_lo_p1 <= res_p0[DATA_W-1:0];
        pend_wr_p1 <= !(is_div && md.rt_val == '0);
      end
      if (finish) begin
        if (pend_wr_p1) begin
          hi_q <= pend_hi_p1;
          lo_q <= pend_lo_p1;
        end
      end else if (state_q == IDLE && md.md_valid) begin
        if (md.md_op == OP_MTHI) hi_q <= md.rs_val;
        if (md.md_op == OP_MTLO) lo_q <= md.rs_val;
      end
    end
  end

  assign md.start    = start;
  assign md.busy     = busy_q;
  assign md.md_stall = md.d_uses_md && (start || busy_q);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed operations against a cycle-indexed model of the
// busy window and HI/LO contents, plus literal result expectations.
module tb_md_unit_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md_unit_ctrl_if md_if();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  // Model: busy is "current cycle index falls inside the issued window".
  longint      cyc = 0;
  longint      win_end = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0, p_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] h,
                                       output logic [31:0] l, output bit wr);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    h  = '0;
    l  = '0;
    wr = 1'b1;
    case (op)
      3'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      3'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd3: if (b == 0) wr = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0]; end
      3'd4: if (b == 0) wr = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; h = ur[31:0]; l = uq[31:0]; end
      default: wr = 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    bit busy_pre;
    if (reset) begin
      m_hi    = '0;
      m_lo    = '0;
      p_live  = 1'b0;
      win_end = -1;
    end else begin
      busy_pre = (cyc <= win_end);
      cyc++;
      if (p_live && cyc > win_end) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        p_live = 1'b0;
      end
      if (md_if.md_valid && (md_if.md_op inside {[1:6]})) begin
        checks++;
        if (busy_pre) begin
          errors++;
          $display("FAIL busy_op actual=op%0d_while_busy required=no_op at %0t", md_if.md_op, $time);
        end
      end
      if (md_if.md_valid && !busy_pre) begin
        if (md_if.md_op inside {[1:4]}) begin
          model_result(md_if.md_op, md_if.rs_val, md_if.rt_val, p_hi, p_lo, p_wr);
          p_live  = 1'b1;
          win_end = cyc - 1 + ((md_if.md_op inside {[3:4]}) ? 10 : 5);
        end else if (md_if.md_op == 3'd5) m_hi = md_if.rs_val;
        else if (md_if.md_op == 3'd6) m_lo = md_if.rs_val;
      end
    end
  end

  initial begin
    forever begin
      bit b, s;
      @(negedge clk);
      #3;
      b = (cyc <= win_end);
      s = md_if.md_valid && (md_if.md_op inside {[1:4]}) && !b;
      chk("start", {31'b0, md_if.start}, {31'b0, s});
      chk("busy", {31'b0, md_if.busy}, {31'b0, b});
      chk("md_stall", {31'b0, md_if.md_stall}, {31'b0, md_if.d_uses_md && (s || b)});
      chk("hi", md_if.hi, m_hi);
      chk("lo", md_if.lo, m_lo);
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit d);
    @(negedge clk);
    md_if.md_valid  = 1'b1;
    md_if.md_op     = op;
    md_if.rs_val    = a;
    md_if.rt_val    = b;
    md_if.d_uses_md = d;
  endtask

  task automatic idle(input int n, input bit d);
    repeat (n) begin
      @(negedge clk);
      md_if.md_valid  = 1'b0;
      md_if.md_op     = 3'd0;
      md_if.d_uses_md = d;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input int exp_stall,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    int nb, ns;
    nb = 0;
    ns = 0;
    drive(op, a, b, 1'b1);
    #3;
    ns += int'(md_if.md_stall);
    repeat (20) begin
      idle(1, 1'b1);
      #3;
      nb += int'(md_if.busy);
      ns += int'(md_if.md_stall);
    end
    chk({name, "_busy_cycles"}, nb, exp_busy);
    chk({name, "_stall_cycles"}, ns, exp_stall);
    chk({name, "_hi"}, md_if.hi, eh);
    chk({name, "_lo"}, md_if.lo, el);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset           = 1'b1;
    md_if.md_valid  = 1'b0;
    md_if.md_op     = 3'd0;
    md_if.rs_val    = '0;
    md_if.rt_val    = '0;
    md_if.d_uses_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("reset_hi", md_if.hi, 32'h0);
    chk("reset_busy", {31'b0, md_if.busy}, 32'h0);

    drive(3'd5, 32'h0000AAAA, 32'h0, 1'b0);
    drive(3'd6, 32'h00005555, 32'h0, 1'b0);
    idle(1, 1'b0);
    #3;
    chk("mt_pre_hi", md_if.hi, 32'h0000AAAA);
    chk("mt_pre_lo", md_if.lo, 32'h00005555);

    run_op(3'd1, 32'hFFFFFFF9, 32'h3, 5, 6, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
    run_op(3'd2, 32'hFFFFFFFF, 32'h2, 5, 6, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5, 6, 32'h40000000, 32'h0, "mult_min");
    run_op(3'd3, 32'hFFFFFFF9, 32'h2, 10, 11, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_op(3'd3, 32'h7, 32'hFFFFFFFE, 10, 11, 32'h1, 32'hFFFFFFFD, "div_negdiv");
    run_op(3'd4, 32'hFFFFFFFF, 32'd10, 10, 11, 32'h5, 32'h19999999, "divu");

    drive(3'd5, 32'h11, 32'h0, 1'b0);
    drive(3'd6, 32'h22, 32'h0, 1'b0);
    run_op(3'd4, 32'd100, 32'h0, 10, 11, 32'h11, 32'h22, "divu_by0");
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 11, 32'h0, 32'h80000000, "div_ovf");

    drive(3'd5, 32'hDEADBEEF, 32'h0, 1'b1);
    #3;
    chk("mthi_start", {31'b0, md_if.start}, 32'h0);
    chk("mthi_stall", {31'b0, md_if.md_stall}, 32'h0);
    drive(3'd6, 32'h12345678, 32'h0, 1'b1);
    #3;
    chk("mthi_hi", md_if.hi, 32'hDEADBEEF);
    idle(1, 1'b0);
    #3;
    chk("mtlo_lo", md_if.lo, 32'h12345678);
    chk("mt_busy", {31'b0, md_if.busy}, 32'h0);

    drive(3'd7, 32'h1, 32'h1, 1'b0);
    @(negedge clk);
    md_if.md_valid = 1'b0;
    md_if.md_op    = 3'd5;
    md_if.rs_val   = 32'hFFFF0000;
    idle(1, 1'b0);
    #3;
    chk("noeffect_hi", md_if.hi, 32'hDEADBEEF);
    chk("noeffect_lo", md_if.lo, 32'h12345678);

    drive(3'd3, 32'd100, 32'd7, 1'b1);
    idle(3, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, md_if.busy}, 32'h0);
    chk("rst_mid_stall", {31'b0, md_if.md_stall}, 32'h0);
    chk("rst_mid_hi", md_if.hi, 32'h0);
    chk("rst_mid_lo", md_if.lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd1, 32'd6, 32'd7, 5, 6, 32'h0, 32'h0000002A, "mult_after_rst");

    idle(2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
